// File: rtl/ahb_arbiter_mux_if.sv
// Signal bundle between the AHB masters and the arbiter/bus multiplexer.
// master modport: the requesting side; slave modport: the arbiter/mux.
interface ahb_arbiter_mux_if #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned MW    = 2
);
  logic [NUM_M-1:0]    hreq;
  logic [NUM_M*AW-1:0] haddr_m;
  logic [NUM_M*2-1:0]  htrans_m;
  logic [NUM_M-1:0]    hwrite_m;
  logic [NUM_M*DW-1:0] hwdata_m;
  logic                hready;
  logic [NUM_M-1:0]    hgrant;
  logic [MW-1:0]       hmaster;
  logic [AW-1:0]       haddr;
  logic [1:0]          htrans;
  logic                hwrite;
  logic [DW-1:0]       hwdata;

  modport master (
    output hreq, haddr_m, htrans_m, hwrite_m, hwdata_m, hready,
    input  hgrant, hmaster, haddr, htrans, hwrite, hwdata
  );

  modport slave (
    input  hreq, haddr_m, htrans_m, hwrite_m, hwdata_m, hready,
    output hgrant, hmaster, haddr, htrans, hwrite, hwdata
  );
endinterface

// File: rtl/ahb_arbiter_mux.sv
// Round-robin AHB arbiter with address-phase and data-phase bus multiplexing.
// Optional per-owner beat quota enabled by defining AHB_ARB_QUOTA_EN.
module ahb_arbiter_mux #(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MW       = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_arbiter_mux_if.slave bus
);

  localparam logic [1:0] TrIdle   = 2'b00;
  localparam logic [1:0] TrNonseq = 2'b10;

  if (NUM_M < 2 || NUM_M > 8 || MAX_HOLD == 0 || (1 << MW) < NUM_M) begin : g_param_check
    $error("ahb_arbiter_mux: invalid parameter set");
  end

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [MW-1:0]    master_q, master_d;
  logic [MW-1:0]    ptr_q, ptr_d;
  logic [MW-1:0]    down_q, down_d;
  logic             dvalid_q, dvalid_d;

  logic             own_req;
  logic [1:0]       own_trans;
  logic [NUM_M-1:0] others;
  logic [MW-1:0]    win;
  logic             handover;
  logic             quota_fire;

  logic [AW-1:0]    addr_mux;
  logic [1:0]       trans_mux;
  logic             write_mux;
  logic [DW-1:0]    wdata_mux;

  // First requester scanning upward from ptr+1, modulo NUM_M.
  function automatic logic [MW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                            input logic [MW-1:0]    ptr);
    logic [MW-1:0] pick;
    logic          found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      for (int unsigned j = 0; j < NUM_M; j++) begin
        if (!found && req[j] && ((32'(ptr) + k) % NUM_M) == j) begin
          pick  = MW'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_M-1:0] onehot(input logic [MW-1:0] idx);
    logic [NUM_M-1:0] g;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      g[i] = (idx == MW'(i));
    end
    return g;
  endfunction

  // Current owner's request/transfer view, and every other master's request.
  always_comb begin
    own_req   = 1'b0;
    own_trans = TrIdle;
    others    = bus.hreq;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (master_q == MW'(i)) begin
        own_req   = bus.hreq[i];
        own_trans = bus.htrans_m[2*i +: 2];
        others[i] = 1'b0;
      end
    end
  end

`ifdef AHB_ARB_QUOTA_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_chg;

  always_comb begin
    quota_fire = (state_q == StOwn) && (32'(cnt_q) >= MAX_HOLD) && (|others) &&
                 (own_trans == TrIdle || own_trans == TrNonseq);
    grant_chg  = (state_q == StIdle) ? (|bus.hreq) : handover;
    cnt_d      = cnt_q;
    if (bus.hready) begin
      if (grant_chg) begin
        cnt_d = '0;
      end else if (state_q == StOwn && own_trans[1] && 32'(cnt_q) < MAX_HOLD) begin
        // Saturates at MAX_HOLD; only the >= comparison matters beyond that.
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign quota_fire = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    master_d = master_q;
    ptr_d    = ptr_q;
    down_d   = down_q;
    dvalid_d = dvalid_q;
    win      = rr_pick((state_q == StIdle) ? bus.hreq : others, ptr_q);
    handover = (state_q == StOwn) &&
               ((!own_req && own_trans == TrIdle) || quota_fire);

    if (bus.hready) begin
      down_d   = master_q;
      dvalid_d = trans_mux[1];
      unique case (state_q)
        StIdle: begin
          if (|bus.hreq) begin
            state_d  = StOwn;
            master_d = win;
            ptr_d    = win;
            grant_d  = onehot(win);
          end
        end
        StOwn: begin
          if (handover) begin
            if (|others) begin
              master_d = win;
              ptr_d    = win;
              grant_d  = onehot(win);
            end else begin
              state_d = StIdle;
              grant_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      master_q <= '0;
      ptr_q    <= MW'(NUM_M - 1);
      down_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      master_q <= master_d;
      ptr_q    <= ptr_d;
      down_q   <= down_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Address phase follows the grant; write data follows the registered data owner.
  always_comb begin
    addr_mux  = '0;
    trans_mux = TrIdle;
    write_mux = 1'b0;
    wdata_mux = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (state_q == StOwn && master_q == MW'(i)) begin
        addr_mux  = bus.haddr_m[i*AW +: AW];
        trans_mux = bus.htrans_m[2*i +: 2];
        write_mux = bus.hwrite_m[i];
      end
      if (dvalid_q && down_q == MW'(i)) begin
        wdata_mux = bus.hwdata_m[i*DW +: DW];
      end
    end
  end

  assign bus.hgrant  = grant_q;
  assign bus.hmaster = master_q;
  assign bus.haddr   = addr_mux;
  assign bus.htrans  = trans_mux;
  assign bus.hwrite  = write_mux;
  assign bus.hwdata  = wdata_mux;

endmodule
